serial_bus_slave: RTL

- Responder end of the serial master/slave bus; one instance per slave (S1, S2) behind the bus interconnect.
- Deserialises a request frame from the bus: mode bit, then local address, then write data if the request is a write.
- Writes are committed into a local word memory. Reads are answered by serialising the stored word back onto the bus.
- The interconnect strips the 2 slave-select bits of the 14-bit global address, so this block sees only the 12-bit local address.

---
 rtl/serial_bus_slave.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/serial_bus_slave.sv
// Serial bus responder: deserialises mode/address/data frames,
// commits writes to local memory and serialises read words back.
module serial_bus_slave #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4096,
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic m_valid,
  input  logic m_bit,
  output logic ready,
  output logic s_valid,
  output logic s_bit
);

  localparam int CMAX0 = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CMAX  = (CMAX0 > MEM_LAT) ? CMAX0 : MEM_LAT;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    RWAIT,
    TX
  } state_t;

  state_t            state;
  logic              mode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  assign in_range = {1'b0, addr} < DEPTH_C;
  assign idx      = addr[IDX_W-1:0];
  assign rd_word  = in_range ? mem[idx] : '0;

  // Memory has no reset; an async reset forces state to IDLE,
  // so a partially received write can never reach this port.
  always_ff @(posedge clk) begin
    if (state == WRITE && in_range) begin
      mem[idx] <= data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mode    <= 1'b0;
      addr    <= '0;
      data    <= '0;
      shreg   <= '0;
      cnt     <= '0;
      ready   <= 1'b1;
      s_valid <= 1'b0;
      s_bit   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m_valid) begin
            mode  <= m_bit;
            cnt   <= '0;
            ready <= 1'b0;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (!m_valid) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            addr <= {m_bit, addr[ADDR_W-1:1]};
            if (cnt == ADDR_LAST) begin
              cnt   <= '0;
              state <= mode ? DATA : RWAIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (!m_valid) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            data <= {m_bit, data[DATA_W-1:1]};
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= WRITE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        RWAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt     <= '0;
            s_valid <= 1'b1;
            s_bit   <= rd_word[0];
            shreg   <= rd_word >> 1;
            state   <= TX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX: begin
          if (cnt == DATA_LAST) begin
            cnt     <= '0;
            s_valid <= 1'b0;
            s_bit   <= 1'b0;
            ready   <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt   <= cnt + 1'b1;
            s_bit <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
